calc_display_drv: RTL
=====================

// Module: calc_display_drv
// PURPOSE
//  Receiving end of the calculator digit stream (status/data/pos).
//  Captures the 8 BCD digits into a shadow buffer while the calculator is busy.
//  Commits a complete frame on the busy->ready edge.
//  Time-multiplexes the committed frame onto 8 common-anode 7-segment displays.
//  Sits between the calculator core and the board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clocks each digit stays lit before the scan advances (>=2)
//  BLANK_LEAD   1      1 = blank leading zeros above the most significant nonzero digit
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high
//  status      in   2  calculator status: 00 error, 01 busy, 10 ready, 11 reserved
//  data        in   4  BCD digit presented for position pos
//  pos         in   4  digit position, 0 = least significant; values >7 are ignored
//  an          out  8  anode enables, active-low, an[i] drives digit i
//  seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//  frame_done  out  1  one-cycle pulse when the shadow buffer is committed
//  err         out  1  sticky error flag
// BEHAVIOUR
//  Reset values (all registers async-cleared):
//   - shadow[0..7] = 0, active[0..7] = 0, prev_status = 01
//   - err = 0, frame_done = 0, scan_idx = 0, div_cnt = 0
//   - an = 8'hFF, seg = 7'h7F
//   - After reset release, the display shows "0" on digit 0; all other digits are blank.
//  Capture:
//   - Each cycle with status==01 and pos<=7, write shadow[pos] <= data.
//   - Last write per position wins.
//  Commit:
//   - Condition: prev_status==01 and status==10 in the same cycle.
//   - Effect: active <= shadow and frame_done = 1 in the next cycle.
//   - The shadow buffer is not cleared.
//   - prev_status is a registered copy of status.
//  Ignored conditions:
//   - Capture never occurs on a commit cycle, because status is 10 on that cycle.
//   - status==11 causes neither capture nor commit.
//   - 10->10 and 00->10 transitions do not commit.
//  Error:
//   - status==00 on any cycle sets err=1; err stays set until reset.
//   - While err=1:
//     * digits 3..0 show E,r,r,o.
//     * digits 7..4 are blanked.
//     * capture and commit are suppressed.
//  Scan:
//   - div_cnt counts 0..REFRESH_DIV-1 and wraps.
//   - On the terminal count, scan_idx <= scan_idx+1 (mod 8, 7 wraps to 0).
//  Output timing:
//   - an and seg are registered and reflect scan_idx one cycle later.
//   - an = ~(8'b1 << scan_idx).
//   - A commit becomes visible on the next registered update; there is no wait for a scan wrap.
//  Decode (active-high pattern, inverted on output; bit order gfedcba):
//   - Digits: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   - Error letters: E=79 r=50 o=5C
//   - BCD values 10..15: blank (seg = 7F).
//  Leading-zero blanking (BLANK_LEAD=1):
//   - Digit i is blanked when active[j]==0 for all j>=i, for i>=1.
//   - Digit 0 is never blanked.
//   - Blanking is evaluated on the active buffer, not on the shadow buffer.
// TESTING (REFRESH_DIV=4)
//  1. Reset mid-scan -> an=FF and seg=7F asynchronously.
//     After release, only an[0]=0, showing seg=~3F ("0").
//  2. status=01, pos 0..7 with data 5,2,1,0,0,0,0,0, then status=10:
//     -> frame_done pulses once.
//     -> digits 2..0 show 1,2,5; digits 7..3 are blank.
//  3. Partial capture of pos 0..3 with no transition to ready -> the displayed frame is unchanged.
//  4. Frame "12345678" followed by a busy phase with pos=9 data=7, then ready:
//     -> the pos=9 write is ignored and the display still shows 12345678.
//  5. status=00 for one cycle, then 01/10 traffic:
//     -> err=1 remains set.
//     -> digits show "Erro", with no frame_done pulse and no capture.
//  6. Scan order check: an sequence FE,FD,FB,...,7F,FE with each value held for exactly 4 cycles.
//     data=12 captured at pos 0 -> digit 0 is blank.

Source files
------------

// File: rtl/calc_display_drv.sv
// Receives the calculator digit stream, double-buffers a frame of 8 BCD digits,
// and scans the committed frame onto 8 common-anode 7-segment displays.
module calc_display_drv #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LEAD  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       err
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  logic [3:0]       r_shadow [8];
  logic [3:0]       r_active [8];
  logic [1:0]       r_prevStatus;
  logic             r_err;
  logic             r_frameDone;
  logic [DIV_W-1:0] r_divCnt;
  logic [2:0]       r_scanIdx;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_capture;
  logic             w_commit;
  logic             w_divWrap;
  logic [7:0]       w_lzBlank;
  logic [3:0]       w_digit;
  logic [6:0]       w_pattern;

  // Active-high gfedcba pattern; codes 10..15 render blank.
  function automatic logic [6:0] bcdToSeg(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  assign w_capture = !r_err && (status == ST_BUSY) && !pos[3];
  assign w_commit  = !r_err && (r_prevStatus == ST_BUSY) && (status == ST_READY);
  assign w_divWrap = (r_divCnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 4'd0;
      end
    end else if (w_capture) begin
      r_shadow[pos[2:0]] <= data;
    end
  end

  // The shadow is left intact on commit so a later frame only needs to resend changed digits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_active[i] <= 4'd0;
      end
      r_frameDone  <= 1'b0;
      r_prevStatus <= ST_BUSY;
      r_err        <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active <= r_shadow;
      end
      r_frameDone  <= w_commit;
      r_prevStatus <= status;
      if (status == ST_ERROR) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_divCnt  <= '0;
      r_scanIdx <= 3'd0;
    end else if (w_divWrap) begin
      r_divCnt  <= '0;
      r_scanIdx <= r_scanIdx + 3'd1;
    end else begin
      r_divCnt  <= r_divCnt + DIV_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it hold zero.
  always_comb begin : leadZero
    logic seenNonzero;
    seenNonzero = 1'b0;
    w_lzBlank   = 8'h00;
    for (int i = 7; i >= 1; i--) begin
      seenNonzero  = seenNonzero | (r_active[i] != 4'd0);
      w_lzBlank[i] = BLANK_LEAD && !seenNonzero;
    end
  end

  always_comb begin
    w_digit   = r_active[r_scanIdx];
    w_pattern = 7'h00;
    if (r_err) begin
      case (r_scanIdx)
        3'd0:    w_pattern = 7'h5C;
        3'd1:    w_pattern = 7'h50;
        3'd2:    w_pattern = 7'h50;
        3'd3:    w_pattern = 7'h79;
        default: w_pattern = 7'h00;
      endcase
    end else if (!w_lzBlank[r_scanIdx]) begin
      w_pattern = bcdToSeg(w_digit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= ~(8'b1 << r_scanIdx);
      r_seg <= ~w_pattern;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frameDone;
  assign err        = r_err;

endmodule
